alm_soa_div16: RTL and testbench

//  Pipelined approximate signed 16/16 divider: the inverse operation of the team's ALM
//  log-domain multiplier. Uses Mitchell logs: log2|x| - log2|y|, then antilog.

---
 rtl/alm_pkg.sv | 39 +++
 rtl/alm_log16_enc.sv | 39 +++
 rtl/alm_soa_div16.sv | 232 +++++++++++++++++++++++
 tb/tb_alm_soa_div16.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alm_pkg.sv
// ----------------------------------------------------------------------------
// alm_pkg
//   Shared constants and types for the ALM (approximate log-domain) arithmetic
//   family: the multiplier and the divider both encode operands as Mitchell
//   logs {k, f}, where k is the leading-one position and f the bits below it.
//
//   Contents
//     K_W       width of the leading-one position (characteristic)
//     OP_W      operand width
//     Q_W       quotient width
//     Q_FRAC    fractional bits of the Q16.16 quotient
//     FRAC_MAX  widest log fraction an encoder produces (MSB-aligned)
//     DBZ_SAT   saturated quotient returned on divide-by-zero
//     log_t     {k, f} with the full-width fraction; users truncate f
//     ones_mag  ones'-complement magnitude used by the whole family
// ----------------------------------------------------------------------------
package alm_pkg;

    localparam int K_W      = 4;
    localparam int OP_W     = 16;
    localparam int Q_W      = 32;
    localparam int Q_FRAC   = 16;
    localparam int FRAC_MAX = OP_W - 1;

    localparam logic [Q_W-1:0] DBZ_SAT = 32'h7FFF_FFFF;

    typedef struct packed {
        logic [K_W-1:0]      k;
        logic [FRAC_MAX-1:0] f;
    } log_t;

    // The family deliberately uses ones' complement rather than two's
    // complement: it is a single XOR row, and the off-by-one on negative
    // inputs is within the error budget of the Mitchell approximation.
    function automatic logic [OP_W-1:0] ones_mag(input logic [OP_W-1:0] v);
        return v ^ {OP_W{v[OP_W-1]}};
    endfunction

endpackage

// File: rtl/alm_log16_enc.sv
// ----------------------------------------------------------------------------
// alm_log16_enc
//   Purely combinational Mitchell log encoder for one 16-bit two's-complement
//   operand: ones'-complement magnitude, leading-one detection, then a
//   normalising shift that MSB-aligns the bits below the leading one.
//
//   Ports
//     v_i     in   16   operand, two's-complement
//     log_o   out  log_t  {k, f}; f is the full 15-bit MSB-aligned fraction
//     zero_o  out  1    magnitude is zero (also true for 16'hFFFF)
// ----------------------------------------------------------------------------
module alm_log16_enc
    import alm_pkg::*;
(
    input  logic [OP_W-1:0] v_i,
    output log_t            log_o,
    output logic            zero_o
);

    logic [OP_W-1:0] mag;
    logic [K_W-1:0]  lead_pos;

    always_comb begin
        mag      = ones_mag(v_i);
        lead_pos = '0;
        // Ascending scan: the last set bit seen is the most significant one.
        for (int i = 0; i < OP_W; i++) begin
            if (mag[i]) begin
                lead_pos = K_W'(i);
            end
        end
        zero_o  = (mag == '0);
        log_o.k = lead_pos;
        // Shifting the leading one up to bit 15 and dropping it leaves the
        // fraction MSB-aligned in the low 15 bits.
        log_o.f = FRAC_MAX'(mag << (K_W'(OP_W - 1) - lead_pos));
    end

endmodule

// File: rtl/alm_soa_div16.sv
// ----------------------------------------------------------------------------
// alm_soa_div16
//   Pipelined approximate signed 16/16 divider using Mitchell logs:
//   log2|x| - log2|y| followed by an antilog. Three register stages with
//   bubble-collapsing valid/ready handshake, one result per cycle.
//
//   Parameters
//     FRAC_W   log fraction bits kept after normalisation (4..15)
//     ID_W     width of the user tag carried with each operation
//
//   Ports
//     clk_i        in   1     clock, rising edge
//     rst_i        in   1     synchronous reset, active-high
//     in_valid_i   in   1     operand pair present
//     in_ready_o   out  1     pair is accepted this cycle
//     x_i          in   16    dividend, two's-complement
//     y_i          in   16    divisor, two's-complement
//     id_i         in   ID_W  tag returned with the result
//     out_valid_o  out  1     result present
//     out_ready_i  in   1     consumer takes the result
//     q_o          out  32    quotient Q16.16, sign applied by ones' complement
//     dbz_o        out  1     divisor magnitude was zero
//     id_o         out  ID_W  tag of this result
// ----------------------------------------------------------------------------
module alm_soa_div16
    import alm_pkg::*;
#(
    parameter int FRAC_W = 8,
    parameter int ID_W   = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [15:0]     x_i,
    input  logic [15:0]     y_i,
    input  logic [ID_W-1:0] id_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     q_o,
    output logic            dbz_o,
    output logic [ID_W-1:0] id_o
);

    localparam int L_W = K_W + FRAC_W;
    localparam int D_W = L_W + 1;

    // ---------------------------------------------------------------- state
    logic            s1_valid_q, s1_valid_d;
    logic [L_W-1:0]  s1_lx_q, s1_lx_d;
    logic [L_W-1:0]  s1_ly_q, s1_ly_d;
    logic            s1_zx_q, s1_zx_d;
    logic            s1_zy_q, s1_zy_d;
    logic            s1_sign_q, s1_sign_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;

    logic            s2_valid_q, s2_valid_d;
    logic [D_W-1:0]  s2_diff_q, s2_diff_d;
    logic            s2_zx_q, s2_zx_d;
    logic            s2_zy_q, s2_zy_d;
    logic            s2_sign_q, s2_sign_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;

    logic            s3_valid_q, s3_valid_d;
    logic [Q_W-1:0]  s3_q_q, s3_q_d;
    logic            s3_dbz_q, s3_dbz_d;
    logic [ID_W-1:0] s3_id_q, s3_id_d;

    // ------------------------------------------------------------ handshake
    logic s1_ready, s2_ready, s3_ready;

    // A stage may load when empty or when its content leaves this cycle, so
    // bubbles collapse. The only combinational path into in_ready_o starts
    // at out_ready_i (and reset).
    always_comb begin
        s3_ready   = ~s3_valid_q | out_ready_i;
        s2_ready   = ~s2_valid_q | s3_ready;
        s1_ready   = ~s1_valid_q | s2_ready;
        in_ready_o = s1_ready & ~rst_i;
    end

    // ------------------------------------------------------------ S1 encode
    log_t lx_enc, ly_enc;
    logic zx_enc, zy_enc;

    alm_log16_enc u_enc_x (
        .v_i    (x_i),
        .log_o  (lx_enc),
        .zero_o (zx_enc)
    );

    alm_log16_enc u_enc_y (
        .v_i    (y_i),
        .log_o  (ly_enc),
        .zero_o (zy_enc)
    );

    // Truncate the MSB-aligned fraction to FRAC_W bits and register the logs.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lx_d    = s1_lx_q;
        s1_ly_d    = s1_ly_q;
        s1_zx_d    = s1_zx_q;
        s1_zy_d    = s1_zy_q;
        s1_sign_d  = s1_sign_q;
        s1_id_d    = s1_id_q;
        if (s1_ready) begin
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_lx_d   = {lx_enc.k, FRAC_W'(lx_enc.f >> (FRAC_MAX - FRAC_W))};
                s1_ly_d   = {ly_enc.k, FRAC_W'(ly_enc.f >> (FRAC_MAX - FRAC_W))};
                s1_zx_d   = zx_enc;
                s1_zy_d   = zy_enc;
                s1_sign_d = x_i[15] ^ y_i[15];
                s1_id_d   = id_i;
            end
        end
    end

    // ---------------------------------------------------------- S2 subtract
    // The extra top bit makes the difference a signed value whose integer
    // part is the exponent of the quotient.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_zx_d    = s2_zx_q;
        s2_zy_d    = s2_zy_q;
        s2_sign_d  = s2_sign_q;
        s2_id_d    = s2_id_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_diff_d = {1'b0, s1_lx_q} - {1'b0, s1_ly_q};
                s2_zx_d   = s1_zx_q;
                s2_zy_d   = s1_zy_q;
                s2_sign_d = s1_sign_q;
                s2_id_d   = s1_id_q;
            end
        end
    end

    // ----------------------------------------------------------- S3 antilog
    logic signed [K_W:0]    exp_val;
    logic [K_W-1:0]         shamt;
    logic [Q_FRAC:0]        mant;
    logic [Q_W-1:0]         mant32;
    logic [Q_W-1:0]         mag32;

    // The mantissa 1.m is placed in Q16.16 and shifted by the exponent.
    // Exponents span -15..14, so the left shift never overflows 32 bits and
    // the right shift simply truncates toward zero.
    always_comb begin
        exp_val = signed'(s2_diff_q[D_W-1:FRAC_W]);
        shamt   = exp_val[K_W] ? K_W'(-exp_val) : exp_val[K_W-1:0];
        mant    = {1'b1, s2_diff_q[FRAC_W-1:0], {(Q_FRAC - FRAC_W){1'b0}}};
        mant32  = {{(Q_W - Q_FRAC - 1){1'b0}}, mant};
        mag32   = exp_val[K_W] ? (mant32 >> shamt) : (mant32 << shamt);
    end

    // Divide-by-zero outranks a zero dividend, and both outrank the sign.
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_q_d     = s3_q_q;
        s3_dbz_d   = s3_dbz_q;
        s3_id_d    = s3_id_q;
        if (s3_ready) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_id_d = s2_id_q;
                if (s2_zy_q) begin
                    s3_q_d   = DBZ_SAT;
                    s3_dbz_d = 1'b1;
                end else if (s2_zx_q) begin
                    s3_q_d   = '0;
                    s3_dbz_d = 1'b0;
                end else begin
                    s3_q_d   = mag32 ^ {Q_W{s2_sign_q}};
                    s3_dbz_d = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_lx_q    <= '0;
            s1_ly_q    <= '0;
            s1_zx_q    <= 1'b0;
            s1_zy_q    <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_diff_q  <= '0;
            s2_zx_q    <= 1'b0;
            s2_zy_q    <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_id_q    <= '0;
            s3_valid_q <= 1'b0;
            s3_q_q     <= '0;
            s3_dbz_q   <= 1'b0;
            s3_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lx_q    <= s1_lx_d;
            s1_ly_q    <= s1_ly_d;
            s1_zx_q    <= s1_zx_d;
            s1_zy_q    <= s1_zy_d;
            s1_sign_q  <= s1_sign_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_diff_q  <= s2_diff_d;
            s2_zx_q    <= s2_zx_d;
            s2_zy_q    <= s2_zy_d;
            s2_sign_q  <= s2_sign_d;
            s2_id_q    <= s2_id_d;
            s3_valid_q <= s3_valid_d;
            s3_q_q     <= s3_q_d;
            s3_dbz_q   <= s3_dbz_d;
            s3_id_q    <= s3_id_d;
        end
    end

    always_comb begin
        out_valid_o = s3_valid_q;
        q_o         = s3_q_q;
        dbz_o       = s3_dbz_q;
        id_o        = s3_id_q;
    end

endmodule

// File: tb/tb_alm_soa_div16.sv
// ----------------------------------------------------------------------------
// tb_alm_soa_div16
//   Directed bench for the approximate divider with FRAC_W=8: single
//   operations with hand-computed quotients, a stall/ordering scenario and a
//   mid-flight reset.
// ----------------------------------------------------------------------------
module tb_alm_soa_div16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] x_i;
    logic [15:0] y_i;
    logic [3:0]  id_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] q_o;
    logic        dbz_o;
    logic [3:0]  id_o;

    int total = 0;
    int bad   = 0;

    alm_soa_div16 #(.FRAC_W(8), .ID_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .id_i        (id_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .q_o         (q_o),
        .dbz_o       (dbz_o),
        .id_o        (id_o)
    );

    always #5 clk_i = ~clk_i;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one operation, waits for acceptance, then counts rising edges
    // (the accepting edge is edge 1) until the result is visible.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [3:0] id,
                                 output int lat, output logic [31:0] q, output logic dbz,
                                 output logic [3:0] ido);
        int guard;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        x_i        = x;
        y_i        = y;
        id_i       = id;
        guard      = 0;
        while (!in_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        lat        = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        q   = q_o;
        dbz = dbz_o;
        ido = id_o;
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] q;
        logic        dbz;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'd100,  16'd10,   32'h000A_8000, 1'b0},
        '{16'h7FFF, 16'd1,    32'h7FC0_0000, 1'b0},
        '{16'd1,    16'h4000, 32'h0000_0004, 1'b0},
        '{16'hFF9B, 16'd10,   32'hFFF5_7FFF, 1'b0},
        '{16'd123,  16'd0,    32'h7FFF_FFFF, 1'b1},
        '{16'd0,    16'd5,    32'h0000_0000, 1'b0},
        '{16'hFF85, 16'hFFFF, 32'h7FFF_FFFF, 1'b1},
        '{16'hFFFF, 16'hFFFF, 32'h7FFF_FFFF, 1'b1},
        '{16'hFFFF, 16'd5,    32'h0000_0000, 1'b0}
    };

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] q;
        logic        dbz;
        logic [3:0]  ido;
        logic [31:0] base_q;
        logic [31:0] exp_q[6];
        int          sent, got, cyc, stale;
        logic        cons, acc;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        x_i         = '0;
        y_i         = '0;
        id_i        = '0;

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_in_ready", 32'(in_ready_o), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_q", q_o, 32'd0);
        checkOutput("rst_dbz", 32'(dbz_o), 32'd0);
        checkOutput("rst_id", 32'(id_o), 32'd0);
        rst_i = 1'b0;

        // Directed single operations.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, 4'(i), lat, q, dbz, ido);
            checkOutput($sformatf("vec%0d_q", i), q, vecs[i].q);
            checkOutput($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
            checkOutput($sformatf("vec%0d_id", i), 32'(ido), 32'(i));
            checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end
        @(negedge clk_i);

        // Backpressure: x=2^n, y=1 gives exactly 2^n in Q16.16.
        base_q = 32'h0001_0000;
        for (int i = 0; i < 6; i++) begin
            exp_q[i] = base_q << i;
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk_i);
            out_ready_i = (cyc >= 6);
            if (sent < 6) begin
                in_valid_i = 1'b1;
                x_i        = 16'(1 << sent);
                y_i        = 16'd1;
                id_i       = 4'(sent);
            end else begin
                in_valid_i = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc < 6) begin
                checkOutput("bp_in_ready_low", 32'(in_ready_o), 32'd0);
                checkOutput("bp_hold_valid", 32'(out_valid_o), 32'd1);
                checkOutput("bp_hold_id", 32'(id_o), 32'd0);
                checkOutput("bp_hold_q", q_o, 32'h0001_0000);
            end
            acc  = in_valid_i & in_ready_o;
            cons = out_valid_o & out_ready_i;
            if (cons) begin
                checkOutput("bp_order_id", 32'(id_o), 32'(got));
                checkOutput("bp_order_q", q_o, exp_q[got]);
                got++;
            end
            if (acc) begin
                sent++;
            end
            cyc++;
        end
        checkOutput("bp_count", 32'(got), 32'd6);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("bp_no_dup", 32'(out_valid_o), 32'd0);

        // Reset with two operations in flight.
        @(negedge clk_i);
        in_valid_i = 1'b1;
        x_i        = 16'd100;
        y_i        = 16'd10;
        id_i       = 4'd7;
        @(negedge clk_i);
        id_i       = 4'd8;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (out_valid_o) begin
                stale++;
            end
        end
        checkOutput("mid_rst_no_stale", 32'(stale), 32'd0);
        applyStimulus(16'd100, 16'd10, 4'd9, lat, q, dbz, ido);
        checkOutput("post_rst_q", q, 32'h000A_8000);
        checkOutput("post_rst_id", 32'(ido), 32'd9);
        checkOutput("post_rst_lat", 32'(lat), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
